// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression, UNROLL rounds/clock.
// Schedule window and K table are internal; job in/out via valid/ready.
module sha256_round_engine #(
    parameter int UNROLL       = 1,
    parameter int FEED_FORWARD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [255:0] chain_in,
    input  logic [511:0] block_in,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest_out,
    output logic         busy,
    output logic [6:0]   round_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL,
        DONE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8))
    begin : g_bad_unroll
        $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
    end

    function automatic logic [31:0] rotr(
        input logic [31:0] x,
        input int          n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One clock of work: UNROLL chained rounds from absolute round t0.
    // Returns {new a..h, window advanced by UNROLL words}.
    function automatic logic [767:0] step(
        input logic [255:0] s,
        input logic [511:0] win,
        input logic [5:0]   t0
    );
        logic [31:0]  v [8];
        logic [31:0]  x [24];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [5:0]   ti;
        logic [767:0] r;
        for (int i = 0; i < 8; i++) begin
            v[i] = s[255-32*i -: 32];
        end
        for (int i = 0; i < 16; i++) begin
            x[i] = win[511-32*i -: 32];
        end
        for (int i = 16; i < 24; i++) begin
            x[i] = '0;
        end
        // Extend the window; later words may use ones built just before.
        for (int j = 0; j < UNROLL; j++) begin
            x[16+j] = ssig1(x[14+j]) + x[9+j]
                    + ssig0(x[1+j]) + x[j];
        end
        for (int j = 0; j < UNROLL; j++) begin
            ti = t0 + 6'(j);
            t1 = v[7] + bsig1(v[4])
               + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + K[ti] + x[j];
            t2 = bsig0(v[0])
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6];
            v[6] = v[5];
            v[5] = v[4];
            v[4] = v[3] + t1;
            v[3] = v[2];
            v[2] = v[1];
            v[1] = v[0];
            v[0] = t1 + t2;
        end
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[767-32*i -: 32] = v[i];
        end
        for (int i = 0; i < 16; i++) begin
            r[511-32*i -: 32] = x[UNROLL+i];
        end
        return r;
    endfunction

    state_t         state;
    state_t         state_nx;
    logic [255:0]   st;
    logic [511:0]   win;
    logic [255:0]   chain;
    logic [767:0]   nxt;
    logic [255:0]   fin;
    logic           accept;

    assign start_ready  = (state == IDLE)
                       || (state == DONE && digest_ready);
    assign accept       = start_valid && start_ready;
    assign busy         = (state == RUN) || (state == FINAL);
    assign digest_valid = (state == DONE);

    // Round datapath for the current clock.
    always_comb begin
        nxt = step(st, win, round_cnt[5:0]);
    end

    // Result word-wise: optional feed-forward of the chaining value.
    always_comb begin
        fin = '0;
        for (int i = 0; i < 8; i++) begin
            if (FEED_FORWARD != 0) begin
                fin[255-32*i -: 32] = chain[255-32*i -: 32]
                                    + st[255-32*i -: 32];
            end else begin
                fin[255-32*i -: 32] = st[255-32*i -: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (round_cnt + 7'(UNROLL) == 7'd64) begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                state_nx = DONE;
            end
            DONE: begin
                if (digest_ready) begin
                    state_nx = start_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Working state, schedule window, chaining value and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= '0;
            win        <= '0;
            chain      <= '0;
            round_cnt  <= '0;
            digest_out <= '0;
        end else begin
            if (accept) begin
                st        <= chain_in;
                win       <= block_in;
                chain     <= chain_in;
                round_cnt <= '0;
            end else if (state == RUN) begin
                st        <= nxt[767:512];
                win       <= nxt[511:0];
                round_cnt <= round_cnt + 7'(UNROLL);
            end
            if (state == FINAL) begin
                digest_out <= fin;
            end
        end
    end

endmodule
